control_unit: RTL
=================

# control_unit

Sequencer for the 16-bit accumulator CPU. It drives the datapath's one-hot control strobes and consumes the datapath's IR, execute-done and indirect-done status, forming the other end of that control interface. It runs a fetch/decode/indirect/execute cycle per instruction, halts on HLT, and counts retired and illegal instructions. It sits between the top-level start/halt controls and the datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles spent waiting in INDIRECT or EXECUTE_MEM before faulting (only with CU_TIMEOUT_EN).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  level; leaves IDLE or HALT.
- i_ir  in  16  current instruction from datapath.
- i_ex_done  in  1  datapath finished a memory-reference execute.
- i_w_mem_ref  in  1  datapath resolved the indirect effective address.
- o_clr_reg, o_fetch, o_execute, o_is_ind, o_is_dir  out  1 each  phase strobes.
- o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac  out  1 each  register-reference strobes.
- o_add, o_load, o_store, o_branch, o_isz  out  1 each  memory-reference strobes.
- o_halted  out  1  in HALT.
- o_illegal  out  1  one-cycle pulse on an illegal instruction.
- o_fault  out  1  sticky watchdog fault.
- o_icount  out  CNT_W  retired instructions.
- o_state  out  3  state encoding, for debug.

## Operation
- Instruction decode: opcode = i_ir[14:12], I = i_ir[15].
  - Memory-reference opcodes: 001 ADD, 010 LDA, 011 STA, 100 BUN, 110 ISZ.
  - Opcodes 000 and 101 are illegal.
- Opcode 111 with I=1 is LDI, which drives o_load_ac.
- Opcode 111 with I=0 is register-reference. i_ir[11:0] must be exactly one-hot:
  - 0x800 CLA, 0x400 CLE, 0x200 CMA, 0x080 CIR, 0x040 CIL, 0x020 INC, 0x001 HLT.
  - Any other value is illegal.
- States: IDLE(0), CLEAR(1), FETCH(2), DECODE(3), INDIRECT(4), EXEC_REG(5), EXEC_MEM(6), HALT(7).
- State transitions:
  - IDLE goes to CLEAR on i_start.
  - CLEAR asserts o_clr_reg, then goes to FETCH.
  - FETCH asserts o_fetch, then goes to DECODE.
  - DECODE samples i_ir and latches the decoded op. It then goes to:
    - INDIRECT for a memory-reference op with I=1;
    - EXEC_MEM for a memory-reference op with I=0;
    - EXEC_REG for register-reference ops and LDI;
    - HALT on HLT;
    - FETCH on an illegal instruction, pulsing o_illegal.
  - INDIRECT holds o_is_ind until i_w_mem_ref=1, then goes to EXEC_MEM.
  - EXEC_REG asserts o_execute plus the one latched strobe for one cycle, then goes to FETCH.
  - EXEC_MEM holds o_execute, o_is_dir and the latched op strobe until i_ex_done=1 is sampled, then goes to FETCH.
  - HALT goes to FETCH on i_start.
- Status inputs are sampled only in the states that own them; they are ignored elsewhere.
- i_start is ignored outside IDLE and HALT.
- o_icount increments, wrapping modulo 2^CNT_W:
  - on leaving EXEC_REG;
  - on leaving EXEC_MEM;
  - on entering HALT.
- Illegal instructions do not increment o_icount.

## Timing
- All outputs are registered (Moore). Strobes change only at posedge clk.
- Reset values:
  - state IDLE;
  - every strobe 0;
  - o_halted, o_illegal and o_fault 0;
  - o_icount 0.
- i_rst in any state:
  - next edge returns to IDLE with all strobes low;
  - an in-flight instruction is abandoned;
  - the datapath is not cleared until the next CLEAR state.
- Latency:
  - register-reference instruction: 3 cycles (FETCH, DECODE, EXEC_REG);
  - direct memory reference: 3 + N, where N is the number of cycles until i_ex_done is sampled;
  - indirect memory reference: adds M cycles in INDIRECT.
- i_ex_done present on the first EXEC_MEM cycle gives N=1.
- If i_ex_done and i_rst are asserted together, reset wins.
- HALT with i_start held high re-enters FETCH on the next cycle.

## Configuration
- CU_TIMEOUT_EN defined: a wait counter runs in INDIRECT and EXEC_MEM.
  - Reaching TIMEOUT_CYCLES without the awaited input forces HALT.
  - o_fault is set and stays at 1 until i_rst.
  - While o_fault=1, i_start is ignored.
- CU_TIMEOUT_EN undefined: the counter is not built, waits are unbounded, and o_fault is tied to 0.

## Structure
- Shared package cu_pkg holds:
  - the state enum and its 3-bit encoding;
  - opcode constants;
  - register-reference bit masks;
  - the decoded-op struct (one bit per strobe, plus is_mem, is_ind, is_hlt, is_illegal).
- One sub-module, ir_decode: combinational, i_ir to the decoded-op struct. It is instantiated once; its output is latched in DECODE.

## Test plan
- Reset then i_start; i_ir=0x7800 (CLA) → o_clr_reg for 1 cycle, then o_fetch, then EXEC_REG with o_clr_ac=1 for exactly 1 cycle; o_icount=1.
- i_ir=0x1005 (direct ADD); i_ex_done asserted 2 cycles into EXEC_MEM → o_add, o_is_dir and o_execute high for 2 cycles; back to FETCH; o_icount increments.
- i_ir=0xA010 (indirect LDA, I=1); i_w_mem_ref after 3 cycles → o_is_ind high for 3 cycles, then EXEC_MEM with o_load=1.
- i_ir=0x7801 (two bits set) → o_illegal pulses once, next state FETCH, o_icount unchanged. Then i_ir=0x7001 (HLT) → o_halted=1; i_start resumes to FETCH.
- With CU_TIMEOUT_EN and TIMEOUT_CYCLES=15: direct STA with no i_ex_done → after 15 cycles o_fault=1 and o_halted=1; i_start is ignored; i_rst clears o_fault.
- Assert i_rst mid EXEC_MEM → next cycle state IDLE, all strobes 0, o_icount 0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-CPU control unit: state encoding,
// opcodes, register-reference masks and the decoded-op record.
package cu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CLEAR    = 3'd1;
    localparam state_t ST_FETCH    = 3'd2;
    localparam state_t ST_DECODE   = 3'd3;
    localparam state_t ST_INDIRECT = 3'd4;
    localparam state_t ST_EXEC_REG = 3'd5;
    localparam state_t ST_EXEC_MEM = 3'd6;
    localparam state_t ST_HALT     = 3'd7;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    localparam logic [11:0] RR_CLA = 12'h800;
    localparam logic [11:0] RR_CLE = 12'h400;
    localparam logic [11:0] RR_CMA = 12'h200;
    localparam logic [11:0] RR_CIR = 12'h080;
    localparam logic [11:0] RR_CIL = 12'h040;
    localparam logic [11:0] RR_INC = 12'h020;
    localparam logic [11:0] RR_HLT = 12'h001;

    typedef struct packed {
        logic clr_ac;
        logic clr_e;
        logic comp_ac;
        logic load_ac;
        logic cir_r;
        logic cir_l;
        logic inc_ac;
        logic add;
        logic load;
        logic store;
        logic branch;
        logic isz;
        logic is_mem;
        logic is_ind;
        logic is_hlt;
        logic is_illegal;
    } dec_op_t;

endpackage

// File: rtl/control_unit_ir_decode.sv
// Combinational instruction decoder: instruction word to one-bit-per-strobe
// record, flagging anything outside the legal opcode / one-hot patterns.
module ir_decode
    import cu_pkg::*;
(
    input  logic [15:0] i_ir,
    output dec_op_t     o_dec
);

    logic [2:0] opcode;
    logic       ind;

    assign opcode = i_ir[14:12];
    assign ind    = i_ir[15];

    always_comb begin
        o_dec = '0;
        case (opcode)
            OP_ADD: begin o_dec.add    = 1'b1; o_dec.is_mem = 1'b1; o_dec.is_ind = ind; end
            OP_LDA: begin o_dec.load   = 1'b1; o_dec.is_mem = 1'b1; o_dec.is_ind = ind; end
            OP_STA: begin o_dec.store  = 1'b1; o_dec.is_mem = 1'b1; o_dec.is_ind = ind; end
            OP_BUN: begin o_dec.branch = 1'b1; o_dec.is_mem = 1'b1; o_dec.is_ind = ind; end
            OP_ISZ: begin o_dec.isz    = 1'b1; o_dec.is_mem = 1'b1; o_dec.is_ind = ind; end
            OP_REG: begin
                if (ind) begin
                    o_dec.load_ac = 1'b1;
                end else begin
                    // Register-reference field must carry exactly one known bit.
                    case (i_ir[11:0])
                        RR_CLA:  o_dec.clr_ac     = 1'b1;
                        RR_CLE:  o_dec.clr_e      = 1'b1;
                        RR_CMA:  o_dec.comp_ac    = 1'b1;
                        RR_CIR:  o_dec.cir_r      = 1'b1;
                        RR_CIL:  o_dec.cir_l      = 1'b1;
                        RR_INC:  o_dec.inc_ac     = 1'b1;
                        RR_HLT:  o_dec.is_hlt     = 1'b1;
                        default: o_dec.is_illegal = 1'b1;
                    endcase
                end
            end
            default: o_dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/indirect/execute sequencer with registered one-hot strobes.
// Optional CU_TIMEOUT_EN adds a wait watchdog that faults into HALT.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [15:0]      i_ir,
    input  logic             i_ex_done,
    input  logic             i_w_mem_ref,
    output logic             o_clr_reg,
    output logic             o_fetch,
    output logic             o_execute,
    output logic             o_is_ind,
    output logic             o_is_dir,
    output logic             o_clr_ac,
    output logic             o_clr_e,
    output logic             o_comp_ac,
    output logic             o_load_ac,
    output logic             o_cir_r,
    output logic             o_cir_l,
    output logic             o_inc_ac,
    output logic             o_add,
    output logic             o_load,
    output logic             o_store,
    output logic             o_branch,
    output logic             o_isz,
    output logic             o_halted,
    output logic             o_illegal,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_icount,
    output logic [2:0]       o_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t  state;
    state_t  state_n;
    dec_op_t dec;
    dec_op_t op_q;
    dec_op_t op_n;
    logic    timeout_hit;
    logic    fault;
    logic    start_ok;
    logic    retire;

    ir_decode u_ir_decode (
        .i_ir  (i_ir),
        .o_dec (dec)
    );

`ifdef CU_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              fault_q;
    logic              waiting;

    assign waiting     = (state == ST_INDIRECT && !i_w_mem_ref) ||
                         (state == ST_EXEC_MEM && !i_ex_done);
    assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            wait_cnt <= (waiting && !timeout_hit) ? wait_cnt + 1'b1 : '0;
            fault_q  <= fault_q | timeout_hit;
        end
    end

    assign fault = fault_q;
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    assign start_ok = i_start && !fault;
    assign op_n     = (state == ST_DECODE) ? dec : op_q;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (start_ok) state_n = ST_CLEAR;
            ST_CLEAR:    state_n = ST_FETCH;
            ST_FETCH:    state_n = ST_DECODE;
            ST_DECODE: begin
                if (dec.is_illegal)  state_n = ST_FETCH;
                else if (dec.is_hlt) state_n = ST_HALT;
                else if (dec.is_mem) state_n = dec.is_ind ? ST_INDIRECT : ST_EXEC_MEM;
                else                 state_n = ST_EXEC_REG;
            end
            ST_INDIRECT: begin
                if (i_w_mem_ref)      state_n = ST_EXEC_MEM;
                else if (timeout_hit) state_n = ST_HALT;
            end
            ST_EXEC_REG: state_n = ST_FETCH;
            ST_EXEC_MEM: begin
                if (i_ex_done)        state_n = ST_FETCH;
                else if (timeout_hit) state_n = ST_HALT;
            end
            ST_HALT:     if (start_ok) state_n = ST_FETCH;
            default:     state_n = ST_IDLE;
        endcase
    end

    // A watchdog exit into HALT is a fault, not a retirement.
    assign retire = (state == ST_EXEC_REG) ||
                    (state == ST_EXEC_MEM && i_ex_done) ||
                    (state == ST_DECODE && dec.is_hlt);

    always_ff @(posedge clk) begin
        if (state == ST_DECODE) op_q <= dec;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            o_clr_reg <= 1'b0;
            o_fetch   <= 1'b0;
            o_execute <= 1'b0;
            o_is_ind  <= 1'b0;
            o_is_dir  <= 1'b0;
            o_clr_ac  <= 1'b0;
            o_clr_e   <= 1'b0;
            o_comp_ac <= 1'b0;
            o_load_ac <= 1'b0;
            o_cir_r   <= 1'b0;
            o_cir_l   <= 1'b0;
            o_inc_ac  <= 1'b0;
            o_add     <= 1'b0;
            o_load    <= 1'b0;
            o_store   <= 1'b0;
            o_branch  <= 1'b0;
            o_isz     <= 1'b0;
            o_halted  <= 1'b0;
            o_illegal <= 1'b0;
            o_icount  <= '0;
        end else begin
            state     <= state_n;
            o_clr_reg <= (state_n == ST_CLEAR);
            o_fetch   <= (state_n == ST_FETCH);
            o_execute <= (state_n == ST_EXEC_REG) || (state_n == ST_EXEC_MEM);
            o_is_ind  <= (state_n == ST_INDIRECT);
            o_is_dir  <= (state_n == ST_EXEC_MEM);
            o_clr_ac  <= (state_n == ST_EXEC_REG) && op_n.clr_ac;
            o_clr_e   <= (state_n == ST_EXEC_REG) && op_n.clr_e;
            o_comp_ac <= (state_n == ST_EXEC_REG) && op_n.comp_ac;
            o_load_ac <= (state_n == ST_EXEC_REG) && op_n.load_ac;
            o_cir_r   <= (state_n == ST_EXEC_REG) && op_n.cir_r;
            o_cir_l   <= (state_n == ST_EXEC_REG) && op_n.cir_l;
            o_inc_ac  <= (state_n == ST_EXEC_REG) && op_n.inc_ac;
            o_add     <= (state_n == ST_EXEC_MEM) && op_n.add;
            o_load    <= (state_n == ST_EXEC_MEM) && op_n.load;
            o_store   <= (state_n == ST_EXEC_MEM) && op_n.store;
            o_branch  <= (state_n == ST_EXEC_MEM) && op_n.branch;
            o_isz     <= (state_n == ST_EXEC_MEM) && op_n.isz;
            o_halted  <= (state_n == ST_HALT);
            o_illegal <= (state == ST_DECODE) && dec.is_illegal;
            if (retire) o_icount <= o_icount + 1'b1;
        end
    end

    assign o_fault = fault;
    assign o_state = state;

endmodule
